// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low row is driven at a time, the column
// lines are synchronized and debounced, and each accepted key gives one pulse.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key,
  output logic       shift,
  output logic       alarm_button,
  output logic       time_button
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  state_t           r_state;
  logic [1:0]       r_row;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_lat_col;
  logic [3:0]       r_key;
  logic             r_shift;
  logic             r_alarm;
  logic             r_time;

  state_t           w_state_nxt;
  logic [1:0]       w_row_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_lat_nxt;
  logic [3:0]       w_key_nxt;
  logic             w_shift_nxt;
  logic             w_alarm_nxt;
  logic             w_time_nxt;
  logic             w_one_low;
  logic             w_window_end;
  logic             w_db_done;
  logic [1:0]       w_col_idx;
  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic             w_is_a;
  logic             w_is_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= col_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_one_low    = ($countones(~r_sync2) == 1);
  assign w_window_end = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_db_done    = (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

  always_comb begin
    case (r_lat_col)
      4'b1110: w_col_idx = 2'd0;
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      default: w_col_idx = 2'd3;
    endcase
  end

  // Keymap: C, D, * and # decode to nothing and are silently swallowed.
  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = '0;
    w_is_a     = 1'b0;
    w_is_b     = 1'b0;
    case ({r_row, w_col_idx})
      4'h0: begin w_is_digit = 1'b1; w_digit = 4'd1; end
      4'h1: begin w_is_digit = 1'b1; w_digit = 4'd2; end
      4'h2: begin w_is_digit = 1'b1; w_digit = 4'd3; end
      4'h3: w_is_a = 1'b1;
      4'h4: begin w_is_digit = 1'b1; w_digit = 4'd4; end
      4'h5: begin w_is_digit = 1'b1; w_digit = 4'd5; end
      4'h6: begin w_is_digit = 1'b1; w_digit = 4'd6; end
      4'h7: w_is_b = 1'b1;
      4'h8: begin w_is_digit = 1'b1; w_digit = 4'd7; end
      4'h9: begin w_is_digit = 1'b1; w_digit = 4'd8; end
      4'hA: begin w_is_digit = 1'b1; w_digit = 4'd9; end
      4'hD: begin w_is_digit = 1'b1; w_digit = 4'd0; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_lat_col;
    w_key_nxt   = r_key;
    w_shift_nxt = 1'b0;
    w_alarm_nxt = 1'b0;
    w_time_nxt  = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_window_end) begin
          w_div_nxt = '0;
          if (w_one_low) begin
            w_lat_nxt   = r_sync2;
            w_cnt_nxt   = '0;
            w_state_nxt = DEBOUNCE;
          end else begin
            w_row_nxt = r_row + 2'd1;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (r_sync2 == r_lat_col) begin
          if (w_db_done) begin
            // Pulses are registered on entry so they are high during EMIT itself.
            w_state_nxt = EMIT;
            w_cnt_nxt   = '0;
            w_shift_nxt = w_is_digit;
            w_alarm_nxt = w_is_a;
            w_time_nxt  = w_is_b;
            if (w_is_digit) begin
              w_key_nxt = w_digit;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = SCAN;
          w_div_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      EMIT: begin
        w_state_nxt = WAIT_RELEASE;
        w_cnt_nxt   = '0;
      end
      WAIT_RELEASE: begin
        if (r_sync2 == '1) begin
          if (w_db_done) begin
            w_state_nxt = SCAN;
            w_row_nxt   = r_row + 2'd1;
            w_div_nxt   = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= SCAN;
      r_row     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_lat_col <= '1;
      r_key     <= '0;
      r_shift   <= 1'b0;
      r_alarm   <= 1'b0;
      r_time    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= w_row_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lat_col <= w_lat_nxt;
      r_key     <= w_key_nxt;
      r_shift   <= w_shift_nxt;
      r_alarm   <= w_alarm_nxt;
      r_time    <= w_time_nxt;
    end
  end

  assign row_out      = ~(4'b0001 << r_row);
  assign key          = r_key;
  assign shift        = r_shift;
  assign alarm_button = r_alarm;
  assign time_button  = r_time;

  a_row_onehot: assert property (@(posedge clock) $onehot(~row_out));
  a_pulse_excl: assert property (@(posedge clock) $onehot0({shift, alarm_button, time_button}));
  a_pulse_once: assert property (@(posedge clock) disable iff (reset)
    (shift || alarm_button || time_button) |=> !(shift || alarm_button || time_button));

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a timeline planner predicts every output per
// cycle from the press table; a few hand-computed values pin the planner.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DB   = 8;
  localparam int MAXT = 400;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key;
  logic       shift;
  logic       alarm_button;
  logic       time_button;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .col_in(col_in), .row_out(row_out),
    .key(key), .shift(shift), .alarm_button(alarm_button), .time_button(time_button)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its column low while its row is driven.
  logic [15:0] press_mask = '0;
  always_comb begin
    col_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && press_mask[r*4+c]) col_in[c] = 1'b0;
  end

  int pk[4], ps[4], pe[4];
  int np = 0;

  logic [3:0] exp_row[MAXT];
  logic [3:0] exp_key[MAXT];
  logic       exp_sh[MAXT], exp_al[MAXT], exp_tb[MAXT];

  typedef struct { int t; int sig; logic [3:0] val; } lit_s;
  lit_s lit_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cur_t = 0;
  bit chk_en = 1'b0;

  function automatic logic [15:0] mask_at(input int t);
    logic [15:0] m = '0;
    for (int i = 0; i < np; i++)
      if (t >= ps[i] && t < pe[i]) m[pk[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] pat(input int t, input int r);
    logic [15:0] m;
    logic [3:0]  p = '1;
    if (t < 0) return p;
    m = mask_at(t);
    for (int c = 0; c < 4; c++)
      if (m[r*4+c]) p[c] = 1'b0;
    return p;
  endfunction

  // 0-9 digits, 10=A 11=B 12=C 13=D 14=* 15=#
  function automatic int code_of(input int idx);
    int tbl[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    return tbl[idx];
  endfunction

  task automatic fill(input int lo, input int hi, input int w);
    logic [3:0] one = 4'b0001;
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < MAXT) exp_row[i] = ~(one << w);
  endtask

  task automatic plan(input int T);
    int a, w, e, m, t, cnt, col, code, tp;
    logic [3:0] p;
    for (int i = 0; i < MAXT; i++) begin
      exp_row[i] = 4'b1110; exp_key[i] = '0;
      exp_sh[i] = 1'b0; exp_al[i] = 1'b0; exp_tb[i] = 1'b0;
    end
    a = 0; w = 0;
    while (a < T) begin
      e = a + SD - 1;
      p = pat(e - 2, w);
      if ($countones(~p) == 1) begin
        m = -1;
        for (int k = e - 1; k <= e + DB - 2; k++)
          if (m < 0 && pat(k, w) != p) m = k;
        if (m >= 0) begin
          fill(a, m + 2, w);
          a = m + 3;
        end else begin
          col = 0;
          for (int c = 0; c < 4; c++) if (!p[c]) col = c;
          code = code_of(w*4 + col);
          tp = e + DB + 1;
          if (tp < MAXT) begin
            if (code < 10) begin
              exp_sh[tp] = 1'b1;
              for (int i = tp; i < MAXT; i++) exp_key[i] = 4'(code);
            end else if (code == 10) exp_al[tp] = 1'b1;
            else if (code == 11) exp_tb[tp] = 1'b1;
          end
          cnt = 0; t = tp + 1;
          while (cnt < DB && t < MAXT) begin
            if (pat(t - 2, w) == 4'b1111) cnt++; else cnt = 0;
            if (cnt < DB) t++;
          end
          fill(a, t, w);
          a = t + 1;
          w = (w + 1) % 4;
        end
      end else begin
        fill(a, a + SD - 1, w);
        a += SD;
        w = (w + 1) % 4;
      end
    end
  endtask

  task automatic check(input string nm, input int t, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", nm, t, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("row_out", cur_t, row_out, exp_row[cur_t]);
      check("key", cur_t, key, exp_key[cur_t]);
      check("shift", cur_t, {3'b000, shift}, {3'b000, exp_sh[cur_t]});
      check("alarm_button", cur_t, {3'b000, alarm_button}, {3'b000, exp_al[cur_t]});
      check("time_button", cur_t, {3'b000, time_button}, {3'b000, exp_tb[cur_t]});
      foreach (lit_q[i]) begin
        if (lit_q[i].t == cur_t) begin
          case (lit_q[i].sig)
            0: check("lit_row", cur_t, row_out, lit_q[i].val);
            1: check("lit_key", cur_t, key, lit_q[i].val);
            2: check("lit_shift", cur_t, {3'b000, shift}, lit_q[i].val);
            3: check("lit_alarm", cur_t, {3'b000, alarm_button}, lit_q[i].val);
            default: check("lit_time", cur_t, {3'b000, time_button}, lit_q[i].val);
          endcase
        end
      end
    end
  end

  task automatic lit(input int t, input int sig, input logic [3:0] v);
    lit_s s;
    s.t = t; s.sig = sig; s.val = v;
    lit_q.push_back(s);
  endtask

  task automatic press(input int i, input int k, input int s, input int e);
    pk[i] = k; ps[i] = s; pe[i] = e;
    if (np < i + 1) np = i + 1;
  endtask

  task automatic run(input int T, input int rst_at);
    chk_en = 1'b0;
    press_mask = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int t = 0; t < T; t++) begin
      cur_t = t;
      press_mask = mask_at(t);
      if (rst_at >= 0 && t == rst_at) reset = 1'b1;
      if (rst_at >= 0 && t == rst_at + 1) begin
        reset = 1'b0;
        press_mask = '0;
      end
      chk_en = 1'b1;
      @(posedge clock);
      #1;
    end
    chk_en = 1'b0;
    lit_q.delete();
    np = 0;
  endtask

  initial begin
    // Idle scan and wrap
    plan(40);
    lit(0, 0, 4'b1110); lit(0, 1, 4'd0); lit(0, 2, 4'd0);
    lit(4, 0, 4'b1101); lit(8, 0, 4'b1011); lit(12, 0, 4'b0111); lit(16, 0, 4'b1110);
    run(40, -1);

    // '5' held 60 cycles
    press(0, 5, 0, 60);
    plan(90);
    lit(15, 2, 4'd0); lit(16, 2, 4'd1); lit(16, 1, 4'd5);
    lit(69, 0, 4'b1101); lit(70, 0, 4'b1011); lit(85, 1, 4'd5);
    run(90, -1);

    // '7' bounce of 5 cycles
    press(0, 8, 8, 13);
    plan(60);
    lit(19, 0, 4'b1011); lit(20, 0, 4'b0111); lit(59, 1, 4'd0);
    run(60, -1);

    // 1, 2, 3, 4
    press(0, 0, 2, 42); press(1, 1, 82, 122); press(2, 2, 162, 202); press(3, 4, 242, 282);
    plan(330);
    lit(28, 2, 4'd1); lit(28, 1, 4'd1); lit(107, 1, 4'd1);
    lit(108, 2, 4'd1); lit(108, 1, 4'd2); lit(329, 1, 4'd4);
    run(330, -1);

    // '8' then A, B, *
    press(0, 9, 2, 42); press(1, 3, 82, 122); press(2, 7, 162, 202); press(3, 12, 242, 282);
    plan(330);
    lit(20, 2, 4'd1); lit(20, 1, 4'd8); lit(100, 3, 4'd1); lit(100, 2, 4'd0); lit(329, 1, 4'd8);
    run(330, -1);

    // '4' and '6' together: two low columns in one row
    press(0, 4, 0, 40); press(1, 6, 0, 40);
    plan(60);
    lit(7, 0, 4'b1101); lit(8, 0, 4'b1011); lit(40, 0, 4'b1011);
    run(60, -1);

    // '9' with reset on debounce cycle 4
    press(0, 10, 8, 16);
    plan(17);
    exp_row[16] = 4'b1110; exp_key[16] = '0;
    exp_sh[16] = 1'b0; exp_al[16] = 1'b0; exp_tb[16] = 1'b0;
    lit(14, 0, 4'b1011); lit(16, 0, 4'b1110); lit(16, 2, 4'd0); lit(16, 1, 4'd0);
    run(17, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter: SCAN_DIV, 4, clocks each row is driven; legal minimum 3.
REQ-002 Parameter: DEBOUNCE_CYCLES, 8, consecutive stable cycles needed to accept a press or a release.
REQ-003 Port: clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: col_in  in  4  keypad column sense lines, active-low, asynchronous to clock.
REQ-006 Port: row_out  out  4  keypad row drive, active-low one-hot.
REQ-007 Port: key  out  4  last accepted digit, binary 0-9; feeds keyreg key input.
REQ-008 Port: shift  out  1  one-cycle pulse per accepted digit; feeds keyreg shift input.
REQ-009 Port: alarm_button  out  1  one-cycle pulse on accepted key A.
REQ-010 Port: time_button  out  1  one-cycle pulse on accepted key B.

Function
REQ-011 col_in SHALL pass through a 2-flop synchronizer (col_sync) before any use.
REQ-012 Keymap (row,col) SHALL be: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = * 0 # D.
REQ-013 A press SHALL qualify only when exactly one col_sync bit is low; zero or multiple low bits mean "no press".
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-015 SCAN: drive current row for SCAN_DIV cycles; evaluate col_sync on the last cycle of the window only; qualified press -> latch row/col, clear counter, go DEBOUNCE; otherwise advance to next row (row3 wraps to row0).
REQ-016 DEBOUNCE: hold row; increment counter each cycle col_sync equals the latched pattern; any mismatch -> SCAN, restart the current row window; counter reaching DEBOUNCE_CYCLES -> EMIT.
REQ-017 EMIT: exactly one cycle; digit -> key updated to the digit and shift=1 in this same cycle; A -> alarm_button=1; B -> time_button=1; C, D, *, # -> no output; always -> WAIT_RELEASE.
REQ-018 WAIT_RELEASE: hold row; count consecutive cycles with col_sync all-ones; any low bit clears the count; count reaching DEBOUNCE_CYCLES -> SCAN on the next row.
REQ-019 Press-to-output latency: shift/button pulse SHALL occur exactly DEBOUNCE_CYCLES+1 cycles after the qualifying SCAN evaluation cycle.
REQ-020 A held key SHALL produce exactly one pulse regardless of hold duration; no auto-repeat.
REQ-021 key SHALL change only in EMIT for digit keys and otherwise hold its value.
REQ-022 shift, alarm_button and time_button SHALL be registered, mutually exclusive, and never high for more than one consecutive cycle.
REQ-023 Presses on other rows while in DEBOUNCE or WAIT_RELEASE SHALL be invisible, because only the held row is driven.

Reset
REQ-024 While reset=1 at a clock edge, the following SHALL hold from the next cycle: state=SCAN; row_out=4'b1110; key=0; shift, alarm_button and time_button = 0; all counters 0; synchronizer flops=4'b1111.
REQ-025 Reset asserted in any state, including mid-DEBOUNCE or EMIT, SHALL override all activity and discard the pending key without any pulse.

Verification
REQ-026 Reset held 2 cycles -> row_out=1110, key=0, shift=0; with no press, row_out cycles 1110,1101,1011,0111 every 4 clocks and wraps.
REQ-027 Digit '5' (row1, col1 low) held 60 cycles -> one shift pulse with key=5 in the same cycle; key stays 5 afterwards; no second pulse before release.
REQ-028 '7' pressed for 5 cycles then released (bounce) -> no shift, key unchanged.
REQ-029 Digits 1, 2, 3, 4, each held 40 cycles then released for 40 cycles -> four shift pulses with key=1, 2, 3, 4 in order (loads keyreg to 12:34).
REQ-030 Key A -> single alarm_button pulse; key B -> single time_button pulse; key '*' -> no pulse; in all three cases shift=0 and key unchanged.
REQ-031 Two column bits low in one row -> no pulse; reset asserted on DEBOUNCE cycle 4 of a valid '9' press -> no shift and row_out=1110 after reset.
